// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: hands out one 2D strided address scan, one address per
// accept on a valid/ready channel, then pulses done for one cycle.
// Optional build macro ADDR_SEQ_PERF_EN adds the stall_cnt output, which
// counts cycles where an address is offered but not taken.
module addr_seq_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32,
  parameter int XSTR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [XSTR_W-1:0] cfg_x_stride,
  input  logic [ADDR_W-1:0] cfg_y_stride,
  input  logic [CNT_W-1:0]  cfg_x_max,
  input  logic [CNT_W-1:0]  cfg_y_max,
  input  logic              abort,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic              busy,
  output logic              done
`ifdef ADDR_SEQ_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [XSTR_W-1:0]  x_stride_q, x_stride_d;
  logic [ADDR_W-1:0]  y_stride_q, y_stride_d;
  logic [CNT_W-1:0]   x_max_q, x_max_d;
  logic [CNT_W-1:0]   y_max_q, y_max_d;

  logic               x_at_max;
  logic               y_at_max;
  logic               cfg_accept;
  logic [ADDR_W-1:0]  x_step;

  // Compare positions against the latched limits and widen the x step.
  assign x_at_max   = (x_q == x_max_q);
  assign y_at_max   = (y_q == y_max_q);
  assign x_step     = ADDR_W'(x_stride_q);

  // cfg_ready is forced low while reset is asserted so nothing is accepted.
  assign cfg_ready  = (state_q == S_IDLE) && !rst;
  assign cfg_accept = cfg_valid && cfg_ready;

  assign addr_valid = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign addr       = addr_q;
  assign addr_last  = (state_q == S_RUN) && x_at_max && y_at_max;

  // State and datapath registers; everything returns to zero on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      x_stride_q <= '0;
      y_stride_q <= '0;
      x_max_q    <= '0;
      y_max_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      x_stride_q <= x_stride_d;
      y_stride_q <= y_stride_d;
      x_max_q    <= x_max_d;
      y_max_q    <= y_max_d;
    end
  end

  // Next-state logic: load a descriptor, step the scan on accept, finish or abort.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    x_stride_d = x_stride_q;
    y_stride_d = y_stride_q;
    x_max_d    = x_max_q;
    y_max_d    = y_max_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_accept) begin
          x_stride_d = cfg_x_stride;
          y_stride_d = cfg_y_stride;
          x_max_d    = cfg_x_max;
          y_max_d    = cfg_y_max;
          x_d        = '0;
          y_d        = '0;
          addr_d     = cfg_base;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // abort wins over a same-cycle accept: that address counts as taken,
        // but the scan stops there without a done pulse.
        if (abort) begin
          state_d = S_IDLE;
        end else if (addr_ready) begin
          if (!x_at_max) begin
            x_d    = x_q + CNT_W'(1);
            addr_d = addr_q + x_step;
          end else if (!y_at_max) begin
            x_d    = '0;
            y_d    = y_q + CNT_W'(1);
            addr_d = addr_q + x_step + y_stride_q;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ADDR_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;

  assign stall_cnt = stall_cnt_q;

  // Count offered-but-not-taken cycles; restart per descriptor, saturate at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (cfg_accept) begin
      stall_cnt_q <= '0;
    end else if (addr_valid && !addr_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Self-checking bench for addr_seq_ctrl. Expected addresses come from a small
// scan model pushed into a queue when a descriptor is driven, and are popped
// as the DUT's addresses are accepted.
module tb_addr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_base;
  logic [15:0] cfg_x_stride;
  logic [31:0] cfg_y_stride;
  logic [31:0] cfg_x_max;
  logic [31:0] cfg_y_max;
  logic        abort;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] addr;
  logic        addr_last;
  logic        busy;
  logic        done;
`ifdef ADDR_SEQ_PERF_EN
  logic [31:0] stall_cnt;
`endif

  typedef struct {
    logic [31:0] a;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  addr_seq_ctrl #(.ADDR_W(32), .CNT_W(32), .XSTR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_base    (cfg_base),
    .cfg_x_stride(cfg_x_stride),
    .cfg_y_stride(cfg_y_stride),
    .cfg_x_max   (cfg_x_max),
    .cfg_y_max   (cfg_y_max),
    .abort       (abort),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .addr        (addr),
    .addr_last   (addr_last),
    .busy        (busy),
    .done        (done)
`ifdef ADDR_SEQ_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Reference scan: row-major walk, x step inside a row, x+y step at row wrap.
  task automatic model_push(input logic [31:0] base, input logic [15:0] xs,
                            input logic [31:0] ys, input int xm, input int ym);
    logic [31:0] a;
    exp_t e;
    a = base;
    for (int yy = 0; yy <= ym; yy++) begin
      for (int xx = 0; xx <= xm; xx++) begin
        e.a    = a;
        e.last = (xx == xm) && (yy == ym);
        exp_q.push_back(e);
        if (xx < xm) a = a + 32'(xs);
        else         a = a + 32'(xs) + ys;
      end
    end
  endtask

  // Offer a descriptor for one cycle starting at a falling edge.
  task automatic send_cfg(input logic [31:0] base, input logic [15:0] xs,
                          input logic [31:0] ys, input int xm, input int ym);
    @(negedge clk);
    cfg_base     = base;
    cfg_x_stride = xs;
    cfg_y_stride = ys;
    cfg_x_max    = 32'(xm);
    cfg_y_max    = 32'(ym);
    cfg_valid    = 1'b1;
    @(negedge clk);
    cfg_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b0 || addr_valid !== 1'b0 || addr !== 32'h0 ||
        addr_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%0b v=%0b a=%h l=%0b busy=%0b done=%0b exp 0 0 0 0 0 0",
               cfg_ready, addr_valid, addr, addr_last, busy, done);
    end else $display("reset_state ok");
`ifdef ADDR_SEQ_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_cfg_ready got %0b exp 1", cfg_ready);
    end else $display("idle cfg_ready ok");
  endtask

  task automatic test_basic();
    exp_t e;
    model_push(32'h100, 16'd4, 32'd8, 2, 1);
    addr_ready = 1'b1;
    send_cfg(32'h100, 16'd4, 32'd8, 2, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (addr_valid !== 1'b1 || addr !== e.a || addr_last !== e.last || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_addr got v=%0b a=%h l=%0b busy=%0b exp v=1 a=%h l=%0b busy=1",
                 addr_valid, addr, addr_last, busy, e.a, e.last);
      end else $display("basic addr=%h last=%0b ok", addr, addr_last);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got done=%0b busy=%0b v=%0b rdy=%0b exp 1 0 0 0",
               done, busy, addr_valid, cfg_ready);
    end else $display("basic done pulse ok");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_after_done got done=%0b rdy=%0b exp 0 1", done, cfg_ready);
    end else $display("basic back to idle ok");
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   c      = 0;
    int   stalls = 0;
    model_push(32'h100, 16'd4, 32'd8, 2, 1);
    send_cfg(32'h100, 16'd4, 32'd8, 2, 1);
    while (exp_q.size() > 0 && c < 200) begin
      addr_ready = (c % 3 == 0);
      e = exp_q[0];
      checks++;
      if (addr_valid !== 1'b1 || addr !== e.a || addr_last !== e.last) begin
        failures++;
        $display("FAIL bp_addr cyc=%0d got v=%0b a=%h l=%0b exp v=1 a=%h l=%0b",
                 c, addr_valid, addr, addr_last, e.a, e.last);
      end else $display("bp cyc=%0d addr=%h last=%0b ready=%0b ok", c, addr, addr_last, addr_ready);
      if (addr_ready) void'(exp_q.pop_front());
      else            stalls++;
      @(negedge clk);
      c++;
    end
    addr_ready = 1'b1;
    checks++;
    if (c >= 200 || done !== 1'b1) begin
      failures++;
      $display("FAIL bp_done got done=%0b cycles=%0d exp done=1 within 200", done, c);
    end else $display("bp done ok stalls=%0d", stalls);
`ifdef ADDR_SEQ_PERF_EN
    checks++;
    if (stall_cnt !== 32'(stalls)) begin
      failures++;
      $display("FAIL bp_stall_cnt got %0d exp %0d", stall_cnt, stalls);
    end else $display("bp stall_cnt=%0d ok", stall_cnt);
`endif
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_degenerate_wrap();
    logic [31:0] bases[2] = '{32'h40, 32'hFFFF_FFF8};
    logic [15:0] xss[2]   = '{16'd4, 16'd4};
    int          xms[2]   = '{0, 3};
    exp_t        e;
    addr_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      model_push(bases[t], xss[t], 32'd0, xms[t], 0);
      send_cfg(bases[t], xss[t], 32'd0, xms[t], 0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (addr_valid !== 1'b1 || addr !== e.a || addr_last !== e.last) begin
          failures++;
          $display("FAIL edge%0d_addr got v=%0b a=%h l=%0b exp v=1 a=%h l=%0b",
                   t, addr_valid, addr, addr_last, e.a, e.last);
        end else $display("edge%0d addr=%h last=%0b ok", t, addr, addr_last);
        @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || addr_valid !== 1'b0) begin
        failures++;
        $display("FAIL edge%0d_done got done=%0b v=%0b exp 1 0", t, done, addr_valid);
      end else $display("edge%0d done ok", t);
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    model_push(32'h100, 16'd4, 32'd8, 2, 1);
    addr_ready = 1'b1;
    send_cfg(32'h100, 16'd4, 32'd8, 2, 1);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (addr_valid !== 1'b1 || addr !== e.a) begin
        failures++;
        $display("FAIL abort_pre_addr got v=%0b a=%h exp v=1 a=%h", addr_valid, addr, e.a);
      end else $display("abort pre addr=%h ok", addr);
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_stop got v=%0b busy=%0b done=%0b rdy=%0b exp 0 0 0 1",
               addr_valid, busy, done, cfg_ready);
    end else $display("abort stop ok");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done got done=%0b v=%0b exp 0 0", done, addr_valid);
    end else $display("abort no done ok");
  endtask

  task automatic test_reset_mid();
    addr_ready = 1'b1;
    send_cfg(32'h100, 16'd4, 32'd8, 2, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (addr_valid !== 1'b0 || addr !== 32'h0 || addr_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got v=%0b a=%h l=%0b busy=%0b done=%0b rdy=%0b exp 0 0 0 0 0 0",
               addr_valid, addr, addr_last, busy, done, cfg_ready);
    end else $display("mid-scan reset ok");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cfg_ready !== 1'b1 || addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after got done=%0b rdy=%0b v=%0b exp 0 1 0", done, cfg_ready, addr_valid);
    end else $display("mid-scan reset release ok");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    addr_ready = 1'b1;
    model_push(32'h100, 16'd4, 32'd8, 2, 1);
    @(negedge clk);
    cfg_base = 32'h100; cfg_x_stride = 16'd4; cfg_y_stride = 32'd8;
    cfg_x_max = 32'd2;  cfg_y_max = 32'd1;    cfg_valid = 1'b1;
    @(negedge clk);
    // second descriptor stays offered for the whole first scan
    cfg_base = 32'hFFFF_FFF8; cfg_x_stride = 16'd4; cfg_y_stride = 32'd0;
    cfg_x_max = 32'd3;        cfg_y_max = 32'd0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (addr_valid !== 1'b1 || addr !== e.a || cfg_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_first got v=%0b a=%h rdy=%0b exp v=1 a=%h rdy=0",
                 addr_valid, addr, cfg_ready, e.a);
      end else $display("b2b first addr=%h ok", addr);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done got done=%0b rdy=%0b exp 1 0", done, cfg_ready);
    end else $display("b2b done ok");
    model_push(32'hFFFF_FFF8, 16'd4, 32'd0, 3, 0);
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got rdy=%0b v=%0b exp 1 0", cfg_ready, addr_valid);
    end else $display("b2b idle accept ok");
    @(negedge clk);
    cfg_valid = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (addr_valid !== 1'b1 || addr !== e.a || addr_last !== e.last) begin
        failures++;
        $display("FAIL b2b_second got v=%0b a=%h l=%0b exp v=1 a=%h l=%0b",
                 addr_valid, addr, addr_last, e.a, e.last);
      end else $display("b2b second addr=%h last=%0b ok", addr, addr_last);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_done got done=%0b exp 1", done);
    end else $display("b2b second done ok");
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_base = '0; cfg_x_stride = '0;
    cfg_y_stride = '0; cfg_x_max = '0; cfg_y_max = '0; abort = 1'b0; addr_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_degenerate_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
